// File: rtl/game_pkg.sv
// Shared game types: the top-level game state, the penalty-round controller
// states, and the helper that decides whether a penalty series is over.
package game_pkg;

  typedef enum logic [1:0] {
    START,
    KEEPER,
    WINNER,
    LOOSER
  } g_state;

  typedef enum logic [2:0] {
    IDLE,
    AIM,
    PAUSE,
    FINISH,
    HOLD
  } r_state;

  localparam int unsigned ROUNDS_DEF    = 5;
  localparam int unsigned WIN_GOALS_DEF = 3;

  // Over when all shots are taken or, with early_end, once the shooter has
  // already won or can no longer reach win_goals with the shots remaining.
  function automatic logic series_decided(
    input logic [3:0] shots_taken,
    input logic [2:0] goals,
    input logic [3:0] rounds,
    input logic [3:0] win_goals,
    input logic       early_end
  );
    logic [3:0] best_case;
    best_case = {1'b0, goals} + (rounds - shots_taken);
    return (shots_taken == rounds) ||
           (early_end && (({1'b0, goals} >= win_goals) || (best_case < win_goals)));
  endfunction

endpackage

// File: rtl/penalty_round_ctrl.sv
// Referee for a solo penalty series: arms each shot window, counts shots and
// goals, paces the pause between shots and reports the series verdict.
module penalty_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned ROUNDS         = ROUNDS_DEF,
  parameter int unsigned WIN_GOALS      = WIN_GOALS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 325_000_000,
  parameter int unsigned PAUSE_CYCLES   = 65_000_000,
  parameter bit          EARLY_END      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  g_state     game_state,
  input  logic       shot_valid,
  input  logic       shot_goal,
  output logic       shot_armed,
  output logic [2:0] score,
  output logic [3:0] round_counter,
  output logic       is_scored,
  output logic       round_done
);

  localparam int unsigned T_MAX = (TIMEOUT_CYCLES > PAUSE_CYCLES) ? TIMEOUT_CYCLES : PAUSE_CYCLES;
  localparam int          TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0] T_SHOT_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_PAUSE_LAST = TW'(PAUSE_CYCLES - 1);
  localparam logic [3:0]    ROUNDS_W     = 4'(ROUNDS);
  localparam logic [3:0]    WIN_W        = 4'(WIN_GOALS);

  r_state        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    score_nxt;
  logic [3:0]    round_counter_nxt;
  logic          is_scored_nxt, round_done_nxt, shot_armed_nxt;
  logic          resolve, goal;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt         = state;
    timer_nxt         = timer;
    score_nxt         = score;
    round_counter_nxt = round_counter;
    is_scored_nxt     = is_scored;
    round_done_nxt    = 1'b0;
    resolve           = 1'b0;
    goal              = 1'b0;

    case (state)
      IDLE: begin
        if (game_state == KEEPER) begin
          score_nxt         = '0;
          round_counter_nxt = '0;
          is_scored_nxt     = 1'b0;
          timer_nxt         = '0;
          state_nxt         = AIM;
        end
      end

      AIM: begin
        if (game_state != KEEPER) begin
          state_nxt = IDLE;
        end else begin
          // A real shot outranks the timeout when both land in the same cycle.
          if (shot_valid) begin
            resolve = 1'b1;
            goal    = shot_goal;
          end else if (timer == T_SHOT_LAST) begin
            resolve = 1'b1;
          end

          if (resolve) begin
            round_counter_nxt = round_counter + 4'd1;
            score_nxt         = (goal && score != 3'd7) ? score + 3'd1 : score;
            timer_nxt         = '0;
            if (series_decided(round_counter_nxt, score_nxt, ROUNDS_W, WIN_W, EARLY_END)) begin
              state_nxt      = FINISH;
              round_done_nxt = 1'b1;
              is_scored_nxt  = ({1'b0, score_nxt} >= WIN_W);
            end else begin
              state_nxt = PAUSE;
            end
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
      end

      PAUSE: begin
        if (game_state != KEEPER) begin
          state_nxt = IDLE;
        end else if (timer == T_PAUSE_LAST) begin
          timer_nxt = '0;
          state_nxt = AIM;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      FINISH: state_nxt = HOLD;

      HOLD: begin
        if (game_state != KEEPER) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    shot_armed_nxt = (state_nxt == AIM);
  end

  // NOTE: state and outputs update with non-blocking assignments so every
  // register samples the same pre-edge values.
  // NOTE: the asynchronous reset puts every output back to 0 at once, so an
  // interrupted series never reports a round_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      score         <= '0;
      round_counter <= '0;
      is_scored     <= 1'b0;
      round_done    <= 1'b0;
      shot_armed    <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      score         <= score_nxt;
      round_counter <= round_counter_nxt;
      is_scored     <= is_scored_nxt;
      round_done    <= round_done_nxt;
      shot_armed    <= shot_armed_nxt;
    end
  end

endmodule

// File: tb/tb_penalty_round_ctrl.sv
// Directed bench for penalty_round_ctrl: an early-ending and a full-length
// instance share stimulus and are compared every cycle against a shot-level model.
module tb_penalty_round_ctrl;
  import game_pkg::*;

  localparam int unsigned TO = 20;
  localparam int unsigned PC = 4;
  localparam int          NR = 5;
  localparam int          NW = 3;

  logic   clk = 1'b0;
  logic   rst;
  g_state game_state;
  logic   shot_valid, shot_goal;

  logic       armed [2];
  logic [2:0] score_o [2];
  logic [3:0] rc_o [2];
  logic       isc [2];
  logic       done [2];

  int n_cmp  = 0;
  int n_fail = 0;
  bit finished = 1'b0;

  always #5 clk = ~clk;

  penalty_round_ctrl #(
    .ROUNDS(NR), .WIN_GOALS(NW), .TIMEOUT_CYCLES(TO), .PAUSE_CYCLES(PC), .EARLY_END(1'b1)
  ) dut_early (
    .clk(clk), .rst(rst), .game_state(game_state), .shot_valid(shot_valid),
    .shot_goal(shot_goal), .shot_armed(armed[0]), .score(score_o[0]),
    .round_counter(rc_o[0]), .is_scored(isc[0]), .round_done(done[0])
  );

  penalty_round_ctrl #(
    .ROUNDS(NR), .WIN_GOALS(NW), .TIMEOUT_CYCLES(TO), .PAUSE_CYCLES(PC), .EARLY_END(1'b0)
  ) dut_full (
    .clk(clk), .rst(rst), .game_state(game_state), .shot_valid(shot_valid),
    .shot_goal(shot_goal), .shot_armed(armed[1]), .score(score_o[1]),
    .round_counter(rc_o[1]), .is_scored(isc[1]), .round_done(done[1])
  );

  // Shot-level model: a series is either running (window open or pausing),
  // finished and waiting for the game to move on, or parked.
  int m_score [2], m_shots [2], m_age [2], m_pause_left [2];
  bit m_running [2], m_waiting [2], m_window [2], m_verdict [2], m_pulse [2];

  task automatic model_step(input int i);
    bit early, keeper, shot, g, decided;
    early  = (i == 0);
    keeper = (game_state == KEEPER);
    if (rst) begin
      m_score[i] = 0; m_shots[i] = 0; m_age[i] = 0; m_pause_left[i] = 0;
      m_running[i] = 0; m_waiting[i] = 0; m_window[i] = 0; m_verdict[i] = 0; m_pulse[i] = 0;
    end else if (m_waiting[i]) begin
      if (m_pulse[i]) m_pulse[i] = 0;
      else if (!keeper) m_waiting[i] = 0;
    end else if (!m_running[i]) begin
      if (keeper) begin
        m_score[i] = 0; m_shots[i] = 0; m_verdict[i] = 0;
        m_running[i] = 1; m_window[i] = 1; m_age[i] = 0;
      end
    end else if (!keeper) begin
      m_running[i] = 0; m_window[i] = 0;
    end else if (m_window[i]) begin
      shot = shot_valid || (m_age[i] == TO - 1);
      if (shot) begin
        g = shot_valid && shot_goal;
        m_shots[i]++;
        if (g && m_score[i] < 7) m_score[i]++;
        decided = (m_shots[i] == NR) ||
                  (early && (m_score[i] >= NW || m_score[i] + (NR - m_shots[i]) < NW));
        m_window[i] = 0;
        if (decided) begin
          m_running[i] = 0; m_waiting[i] = 1; m_pulse[i] = 1;
          m_verdict[i] = (m_score[i] >= NW);
        end else begin
          m_pause_left[i] = PC;
        end
      end else begin
        m_age[i]++;
      end
    end else begin
      m_pause_left[i]--;
      if (m_pause_left[i] == 0) begin
        m_window[i] = 1; m_age[i] = 0;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  function automatic logic [9:0] act_vec(input int i);
    return {armed[i], score_o[i], rc_o[i], isc[i], done[i]};
  endfunction

  function automatic logic [9:0] exp_vec(input int i);
    return {m_window[i], 3'(m_score[i]), 4'(m_shots[i]), m_verdict[i], m_pulse[i]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Literal expectation, fields {armed, score, round_counter, is_scored, round_done}.
  task automatic chk(input string name, input int i, input logic a, input logic [2:0] s,
                     input logic [3:0] r, input logic v, input logic d);
    check(name, 32'(act_vec(i)), 32'({a, s, r, v, d}));
  endtask

  always @(posedge clk) begin
    #2;
    if (!finished) begin
      check("early_vs_model", 32'(act_vec(0)), 32'(exp_vec(0)));
      check("full_vs_model", 32'(act_vec(1)), 32'(exp_vec(1)));
    end
  end

  task automatic shot(input logic g);
    shot_valid = 1'b1;
    shot_goal  = g;
    @(negedge clk);
    shot_valid = 1'b0;
    shot_goal  = 1'b0;
  endtask

  task automatic wait_armed(input int i);
    int k;
    k = 0;
    while (armed[i] !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (armed[i] !== 1'b1) check("wait_armed_timeout", 32'(armed[i]), 32'd1);
  endtask

  initial begin
    int high, low;
    rst = 1'b1; game_state = START; shot_valid = 1'b0; shot_goal = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_early", 0, 0, 0, 0, 0, 0);
    chk("reset_full", 1, 0, 0, 0, 0, 0);

    // Two goals, then reset in the middle of the next window.
    game_state = KEEPER;
    wait_armed(0); shot(1'b1);
    wait_armed(0); shot(1'b1);
    chk("two_goals", 0, 0, 3'd2, 4'd2, 0, 0);
    wait_armed(0);
    rst = 1'b1;
    #1;
    chk("rst_mid_aim", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Three straight goals end the early series on the third.
    for (int k = 0; k < 3; k++) begin
      wait_armed(0); shot(1'b1);
    end
    chk("goal3_done_early", 0, 0, 3'd3, 4'd3, 1, 1);
    chk("goal3_full_continues", 1, 0, 3'd3, 4'd3, 0, 0);
    @(negedge clk);
    chk("done_one_cycle", 0, 0, 3'd3, 4'd3, 1, 0);
    shot(1'b1);
    chk("shot_in_hold", 0, 0, 3'd3, 4'd3, 1, 0);
    chk("shot_in_pause", 1, 0, 3'd3, 4'd3, 0, 0);
    game_state = LOOSER;
    repeat (3) @(negedge clk);
    chk("looser_keeps_score", 0, 0, 3'd3, 4'd3, 1, 0);

    // All saves: early series ends at three, full series at five.
    game_state = KEEPER;
    for (int k = 0; k < 3; k++) begin
      wait_armed(0); shot(1'b0);
    end
    chk("save3_early_done", 0, 0, 0, 4'd3, 0, 1);
    chk("save3_full_running", 1, 0, 0, 4'd3, 0, 0);
    for (int k = 0; k < 2; k++) begin
      wait_armed(1); shot(1'b0);
    end
    chk("save5_full_done", 1, 0, 0, 4'd5, 0, 1);
    game_state = START;
    repeat (2) @(negedge clk);

    // Shot window timeout and pause length.
    game_state = KEEPER;
    wait_armed(0);
    high = 0;
    while (armed[0] === 1'b1 && high < 100) begin
      high++;
      @(negedge clk);
    end
    check("timeout_window_len", high, 20);
    chk("timeout_is_save", 0, 0, 0, 4'd1, 0, 0);
    low = 0;
    while (armed[0] !== 1'b1 && low < 100) begin
      low++;
      @(negedge clk);
    end
    check("pause_len", low, 4);

    // Goal landing in the timeout cycle still counts.
    repeat (TO - 1) @(negedge clk);
    shot(1'b1);
    chk("goal_in_timeout_cycle", 0, 0, 3'd1, 4'd2, 0, 0);

    // Leaving KEEPER mid-window, then re-entering.
    wait_armed(0);
    game_state = START;
    @(negedge clk);
    chk("leave_keeper_early", 0, 0, 3'd1, 4'd2, 0, 0);
    chk("leave_keeper_full", 1, 0, 3'd1, 4'd2, 0, 0);
    repeat (3) @(negedge clk);
    chk("idle_holds_score", 0, 0, 3'd1, 4'd2, 0, 0);
    game_state = KEEPER;
    @(negedge clk);
    chk("reenter_clears", 0, 1, 0, 0, 0, 0);

    game_state = START;
    repeat (3) @(negedge clk);
    finished = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/penalty_round_ctrl.md
Name: penalty_round_ctrl

Overview:
- Referees a solo-mode penalty series while the game is in KEEPER.
- Counts shots and goals, times each shot window and the pause between shots, and decides the series outcome.
- Drives `round_done` and `is_scored` directly into the game state selector, which moves to LOOSER or WINNER on them.
- Shot events come from the ball/keeper collision logic upstream.

Parameters:
- ROUNDS, 5: shots per series; legal range 1..7.
- WIN_GOALS, 3: goals at which the shooter wins (the keeper loses); legal range 1..ROUNDS.
- TIMEOUT_CYCLES, 325_000_000: shot window length, 5 s at 65 MHz.
- PAUSE_CYCLES, 65_000_000: gap between shots, 1 s at 65 MHz.
- EARLY_END, 1: when 1, end the series as soon as the outcome is mathematically decided.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- game_state  in  g_state  current state from the game state selector
- shot_valid  in  1  one-cycle pulse: a shot has resolved
- shot_goal  in  1  qualifies shot_valid; 1 = goal, 0 = saved
- shot_armed  out  1  high while a shot window is open (AIM); upstream may fire only then
- score  out  3  goals so far in the current or last series
- round_counter  out  4  shots resolved so far
- is_scored  out  1  series verdict: 1 = shooter reached WIN_GOALS
- round_done  out  1  one-cycle pulse at the end of the series

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timer 0. Reset asserted mid-operation returns to these immediately, with no round_done.
- All outputs are registered.
- One shared timer, width $clog2(max(TIMEOUT_CYCLES, PAUSE_CYCLES)).
- FSM states are IDLE, AIM, PAUSE, FINISH, HOLD.
- IDLE:
  - When game_state == KEEPER: clear score, round_counter, is_scored and timer; go to AIM.
  - Otherwise hold all values, so scores remain visible on the WINNER/LOOSER screens.
- AIM: shot_armed = 1; timer increments every cycle. A shot resolves when either:
  - shot_valid = 1: goal = shot_goal;
  - timer == TIMEOUT_CYCLES-1 with no shot_valid: counted as a save.
  - If shot_valid arrives in the timeout cycle, shot_valid wins.
- On resolve, in the next cycle:
  - round_counter += 1;
  - score += goal, saturating at 7;
  - timer cleared.
- Decision after resolve, using the updated values:
  - done = (round_counter == ROUNDS) OR (EARLY_END AND (score >= WIN_GOALS OR score + (ROUNDS - round_counter) < WIN_GOALS)).
  - done → FINISH; otherwise → PAUSE.
- PAUSE:
  - shot_armed = 0; shot_valid is ignored.
  - timer counts to PAUSE_CYCLES-1, then clears and the FSM goes to AIM.
- FINISH (exactly one cycle):
  - round_done = 1.
  - is_scored = (score >= WIN_GOALS), valid in the same cycle as round_done and held afterwards.
  - Next state is HOLD.
- HOLD: wait until game_state != KEEPER, then go to IDLE. shot_valid is ignored.
- Latency: shot_valid sampled in cycle n → score and round_counter updated in n+1.
  - Final shot at n → FINISH, round_done and is_scored in n+1.
- Leaving KEEPER early: if game_state != KEEPER while in AIM or PAUSE, go to IDLE next cycle.
  - No round_done; counters are held until the next KEEPER entry clears them.
- shot_valid is ignored in every state except AIM; shot_goal is ignored without shot_valid.
- Arithmetic is unsigned. The remaining-shots term uses 4-bit width, so it never underflows because round_counter <= ROUNDS.

Decomposition:
- game_pkg additions:
  - typedef enum r_state {IDLE, AIM, PAUSE, FINISH, HOLD};
  - constants ROUNDS_DEF = 5, WIN_GOALS_DEF = 3.
- The existing g_state is reused for the game_state port.
- No sub-module: one FSM plus one shared timer in a single file.

Test Plan (TIMEOUT_CYCLES=20, PAUSE_CYCLES=4, defaults otherwise):
- Reset → all outputs 0, shot_armed 0. Assert rst mid-AIM after 2 goals → score 0, round_counter 0 immediately; no round_done.
- game_state=KEEPER, shots goal, goal, goal (EARLY_END=1) → after shot 3: score 3, round_counter 3, is_scored 1, round_done one-cycle pulse 1 cycle after the 3rd shot_valid. Then game_state=LOOSER → IDLE, score stays 3.
- Saves on shots 1-3 (EARLY_END=1) → round_done after shot 3 with is_scored 0, score 0. Same stimulus with EARLY_END=0 → round_done only after shot 5, round_counter 5.
- No shot_valid in AIM → round_counter becomes 1 on the cycle after the 20th AIM cycle; score unchanged; PAUSE lasts 4 cycles, then shot_armed re-rises.
- shot_valid with shot_goal=1 in the timeout cycle → counted as a goal (score 1). shot_valid pulses in PAUSE or HOLD → no counter change.
- game_state to START during AIM after 1 goal → IDLE next cycle, no round_done, score holds 1. Re-entering KEEPER → score 0, round_counter 0, is_scored 0.
